// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain loader and its serializer.
package ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } ccff_state_e;

  // Config flip-flop count per switch-block type: 4x3 + 2x3 + 2x2 + 7x2
  localparam int unsigned SB_1__3_CHAIN_LEN = 36;

  localparam int unsigned CCFF_WORD_W = 8;
  localparam int unsigned CCFF_ERR_W  = 16;

  // Bitstream length in words for a chain; the last word may be partial.
  function automatic int unsigned ccff_num_words(input int unsigned chain_len,
                                                 input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream stream, pass control and chain serial signals of the loader.
interface ccff_chain_loader_if
  import ccff_pkg::*;
#(
  parameter int unsigned WORD_W = CCFF_WORD_W,
  parameter int unsigned ERR_W  = CCFF_ERR_W
);

  logic              start;
  logic              verify;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              ccff_head;
  logic              chain_clk_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic [ERR_W-1:0]  err_cnt;

  // Programming host plus the chain it drives
  modport master (
    output start, verify, s_data, s_valid, ccff_tail,
    input  s_ready, ccff_head, chain_clk_en, busy, done, err_cnt
  );

  // Loader side
  modport slave (
    input  start, verify, s_data, s_valid, ccff_tail,
    output s_ready, ccff_head, chain_clk_en, busy, done, err_cnt
  );

endinterface

// File: rtl/ccff_word_serializer.sv
// Shifts one bitstream word out LSB first, stopping after a programmable bit count.
module ccff_word_serializer #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  input  logic [CNT_W-1:0]  nbits,
  input  logic              shift,
  output logic              head_bit,
  output logic              last_bit
);

  logic [WORD_W-1:0] sreg;
  logic [CNT_W-1:0]  rem;

  // head_bit holds the bit on the wire; sreg holds the bits still to come
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg     <= '0;
      rem      <= '0;
      head_bit <= 1'b0;
    end else if (load) begin
      sreg     <= data >> 1;
      rem      <= nbits;
      head_bit <= data[0];
    end else if (shift) begin
      sreg     <= sreg >> 1;
      rem      <= rem - CNT_W'(1);
      head_bit <= last_bit ? 1'b0 : sreg[0];
    end
  end

  assign last_bit = (rem == CNT_W'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Source end of a ccff_head -> ccff_tail configuration chain: serialises a
// bitstream into the chain and optionally compares the tail on a re-shift.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = SB_1__3_CHAIN_LEN,
  parameter int unsigned WORD_W    = CCFF_WORD_W,
  parameter int unsigned ERR_W     = CCFF_ERR_W
) (
  input logic                prog_clk,
  input logic                pReset,
  ccff_chain_loader_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned CNT_W = $clog2(WORD_W + 1);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] FETCH = ST_FETCH;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [IDX_W-1:0] bit_idx;
  logic             verify_q;
  logic             load;
  logic             shift;
  logic             last_bit;
  logic             chain_end;
  logic [31:0]      bits_left;
  logic [CNT_W-1:0] word_bits;

  // Bits this word contributes; the tail of a partial last word is dropped
  assign bits_left = 32'(CHAIN_LEN) - 32'(bit_idx);
  assign word_bits = (bits_left >= 32'(WORD_W)) ? CNT_W'(WORD_W) : CNT_W'(bits_left);
  assign chain_end = (32'(bit_idx) + 32'd1 == 32'(CHAIN_LEN));

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nxt = FETCH;
      FETCH: begin
        if (bus.s_valid && bus.s_ready) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (last_bit) state_nxt = chain_end ? DONE : FETCH;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs registered from the next state so they line up with the state
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      bus.s_ready      <= 1'b0;
      bus.chain_clk_en <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      bus.s_ready      <= (state_nxt == FETCH);
      bus.chain_clk_en <= (state_nxt == SHIFT);
      bus.busy         <= (state_nxt != IDLE);
      bus.done         <= (state_nxt == DONE);
    end
  end

  // Pass bookkeeping; the tail sampled on a shifting edge pairs with the head bit
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      verify_q    <= 1'b0;
      bit_idx     <= '0;
      bus.err_cnt <= '0;
    end else if (state == IDLE && bus.start) begin
      verify_q    <= bus.verify;
      bit_idx     <= '0;
      bus.err_cnt <= '0;
    end else if (shift) begin
      bit_idx <= bit_idx + IDX_W'(1);
      if (verify_q && (bus.ccff_tail != bus.ccff_head) && (bus.err_cnt != '1))
        bus.err_cnt <= bus.err_cnt + ERR_W'(1);
    end
  end

  ccff_word_serializer #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_ser (
    .clk      (prog_clk),
    .rst      (pReset),
    .load     (load),
    .data     (bus.s_data),
    .nbits    (word_bits),
    .shift    (shift),
    .head_bit (bus.ccff_head),
    .last_bit (last_bit)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 36-bit and a 16-bit chain, each modelled as a
// plain shift register fed by ccff_head and gated by chain_clk_en.
module tb_ccff_chain_loader;
  import ccff_pkg::*;

  localparam int unsigned LEN_A = SB_1__3_CHAIN_LEN;
  localparam int unsigned NW_A  = ccff_num_words(LEN_A, 8);
  localparam int unsigned LEN_B = 16;
  localparam int unsigned NW_B  = ccff_num_words(LEN_B, 8);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ccff_chain_loader_if #(.WORD_W(8), .ERR_W(16)) bus_a ();
  ccff_chain_loader_if #(.WORD_W(8), .ERR_W(16)) bus_b ();

  ccff_chain_loader #(.CHAIN_LEN(LEN_A), .WORD_W(8), .ERR_W(16)) dut_a (
    .prog_clk (clk), .pReset (rst), .bus (bus_a));
  ccff_chain_loader #(.CHAIN_LEN(LEN_B), .WORD_W(8), .ERR_W(16)) dut_b (
    .prog_clk (clk), .pReset (rst), .bus (bus_b));

  int checks = 0;
  int errors = 0;

  logic [LEN_A-1:0] chain_a;
  logic [LEN_B-1:0] chain_b;
  int en_cnt_a = 0, busy_cnt_a = 0, done_cnt_a = 0, viol_a = 0;
  int en_cnt_b = 0, busy_cnt_b = 0, done_cnt_b = 0;

  assign bus_a.ccff_tail = chain_a[LEN_A-1];
  assign bus_b.ccff_tail = chain_b[LEN_B-1];

  // External chains and activity counters, sampling values of the closing cycle
  always @(posedge clk) begin
    if (bus_a.chain_clk_en) begin
      chain_a  <= {chain_a[LEN_A-2:0], bus_a.ccff_head};
      en_cnt_a <= en_cnt_a + 1;
    end
    if (bus_a.busy) busy_cnt_a <= busy_cnt_a + 1;
    if (bus_a.done) done_cnt_a <= done_cnt_a + 1;
    if ((!bus_a.chain_clk_en && bus_a.ccff_head) || (bus_a.chain_clk_en && bus_a.s_ready))
      viol_a <= viol_a + 1;
    if (bus_b.chain_clk_en) begin
      chain_b  <= {chain_b[LEN_B-2:0], bus_b.ccff_head};
      en_cnt_b <= en_cnt_b + 1;
    end
    if (bus_b.busy) busy_cnt_b <= busy_cnt_b + 1;
    if (bus_b.done) done_cnt_b <= done_cnt_b + 1;
  end

  logic [7:0] words_a [NW_A];
  logic [7:0] words_b [NW_B];
  logic [LEN_A-1:0] prev_a;
  int en0, busy0, done0, viol0;

  // Stream bit k (word k/8, bit k%8) ends up k places from the chain tail
  function automatic logic [LEN_A-1:0] exp_chain_a();
    logic [LEN_A-1:0] v;
    v = '0;
    for (int k = 0; k < int'(LEN_A); k++) v[int'(LEN_A) - 1 - k] = words_a[k / 8][k % 8];
    return v;
  endfunction

  function automatic logic [LEN_B-1:0] exp_chain_b();
    logic [LEN_B-1:0] v;
    v = '0;
    for (int k = 0; k < int'(LEN_B); k++) v[int'(LEN_B) - 1 - k] = words_b[k / 8][k % 8];
    return v;
  endfunction

  task automatic snap_a();
    en0 = en_cnt_a; busy0 = busy_cnt_a; done0 = done_cnt_a; viol0 = viol_a;
  endtask

  // Host side of one pass on chain A, with optional stall, stray start and abort
  task automatic drive_a(input logic vmode, input int stall_word, input int stall_len,
                         input int start_at, input int abort_at,
                         output bit timed_out, output logic abort_en, output logic abort_busy);
    int w, stall, cyc, e0;
    bit drove, rdy;
    w = 0; stall = stall_len; cyc = 0; drove = 0; rdy = 0; e0 = en_cnt_a;
    timed_out = 0; abort_en = 1'bx; abort_busy = 1'bx;
    @(negedge clk); bus_a.start = 1'b1; bus_a.verify = vmode;
    @(negedge clk); bus_a.start = 1'b0; bus_a.verify = ~vmode;
    forever begin
      if (drove && rdy) w++;
      if (bus_a.done) break;
      if (abort_at > 0 && (en_cnt_a - e0) >= abort_at) begin
        #2 rst = 1'b1;
        #1 abort_en = bus_a.chain_clk_en; abort_busy = bus_a.busy;
        @(negedge clk); rst = 1'b0;
        break;
      end
      if (cyc > 300) begin timed_out = 1; break; end
      rdy = bus_a.s_ready;
      drove = 0;
      bus_a.start = (cyc == start_at);
      if (w == stall_word && stall > 0) begin
        bus_a.s_valid = 1'b0;
        if (rdy) stall--;
      end else if (w < int'(NW_A)) begin
        bus_a.s_valid = 1'b1; bus_a.s_data = words_a[w]; drove = 1;
      end else begin
        bus_a.s_valid = 1'($urandom); bus_a.s_data = 8'($urandom);
      end
      @(negedge clk); cyc++;
    end
    bus_a.s_valid = 1'b0; bus_a.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive_b(input logic vmode, output bit timed_out);
    int w, cyc;
    bit drove, rdy;
    w = 0; cyc = 0; drove = 0; rdy = 0; timed_out = 0;
    @(negedge clk); bus_b.start = 1'b1; bus_b.verify = vmode;
    @(negedge clk); bus_b.start = 1'b0;
    forever begin
      if (drove && rdy) w++;
      if (bus_b.done) break;
      if (cyc > 100) begin timed_out = 1; break; end
      rdy = bus_b.s_ready;
      drove = (w < int'(NW_B));
      bus_b.s_valid = drove;
      bus_b.s_data = drove ? words_b[w] : 8'h00;
      @(negedge clk); cyc++;
    end
    bus_b.s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.start = 0; bus_a.verify = 0; bus_a.s_valid = 0; bus_a.s_data = '0;
    bus_b.start = 0; bus_b.verify = 0; bus_b.s_valid = 0; bus_b.s_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus_a.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", bus_a.s_ready); end
    checks++; if (bus_a.ccff_head !== 1'b0) begin errors++; $display("FAIL reset_head got %b want 0", bus_a.ccff_head); end
    checks++; if (bus_a.chain_clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en got %b want 0", bus_a.chain_clk_en); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus_a.busy); end
    checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus_a.done); end
    checks++; if (bus_a.err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err got %0d want 0", bus_a.err_cnt); end
    checks++; if (bus_b.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_b got %b want 0", bus_b.busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus_a.s_ready !== 1'b0) begin errors++; $display("FAIL idle_no_start got %b want 0", bus_a.s_ready); end
  endtask

  task automatic test_load_basic();
    bit to; logic ae, ab;
    words_a = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h0B};
    snap_a();
    drive_a(1'b0, -1, 0, -1, 0, to, ae, ab);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL load_timeout done not seen"); end
    checks++; if (en_cnt_a - en0 !== 36) begin errors++; $display("FAIL load_enables got %0d want 36", en_cnt_a - en0); end
    checks++; if (busy_cnt_a - busy0 !== 42) begin errors++; $display("FAIL load_cycles got %0d want 42", busy_cnt_a - busy0); end
    checks++; if (done_cnt_a - done0 !== 1) begin errors++; $display("FAIL load_done got %0d want 1", done_cnt_a - done0); end
    checks++; if (chain_a !== exp_chain_a()) begin errors++; $display("FAIL load_chain got %h want %h", chain_a, exp_chain_a()); end
    checks++; if (bus_a.err_cnt !== 16'd0) begin errors++; $display("FAIL load_err got %0d want 0", bus_a.err_cnt); end
    checks++; if (viol_a - viol0 !== 0) begin errors++; $display("FAIL load_idle_levels got %0d want 0", viol_a - viol0); end
    prev_a = exp_chain_a();
  endtask

  task automatic test_verify_same();
    bit to; logic ae, ab;
    checks++; if (bus_a.ccff_tail !== 1'b1) begin errors++; $display("FAIL verify_first_tail got %b want 1", bus_a.ccff_tail); end
    snap_a();
    drive_a(1'b1, -1, 0, -1, 0, to, ae, ab);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL verify_timeout done not seen"); end
    checks++; if (bus_a.err_cnt !== 16'd0) begin errors++; $display("FAIL verify_same_err got %0d want 0", bus_a.err_cnt); end
    checks++; if (chain_a !== prev_a) begin errors++; $display("FAIL verify_chain got %h want %h", chain_a, prev_a); end
    checks++; if (en_cnt_a - en0 !== 36) begin errors++; $display("FAIL verify_enables got %0d want 36", en_cnt_a - en0); end
  endtask

  task automatic test_verify_errors();
    bit to; logic ae, ab;
    logic [7:0] orig [NW_A];
    int want [5];
    orig = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h0B};
    want = '{1, 1, 36, 0, 0};
    for (int s = 0; s < 5; s++) begin
      words_a = orig;
      if (s == 0) words_a[2][3] = ~words_a[2][3];
      if (s >= 2 && s <= 3) for (int i = 0; i < int'(NW_A); i++) words_a[i] = ~orig[i];
      if (s == 3) words_a[4][6] = ~words_a[4][6];
      drive_a((s < 4) ? 1'b1 : 1'b0, -1, 0, -1, 0, to, ae, ab);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL verr_timeout step %0d", s); end
      checks++;
      if (bus_a.err_cnt !== 16'(want[s])) begin
        errors++; $display("FAIL verify_err step %0d got %0d want %0d", s, bus_a.err_cnt, want[s]);
      end
    end
    prev_a = exp_chain_a();
  endtask

  task automatic test_stall();
    bit to; logic ae, ab;
    words_a = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h0B};
    snap_a();
    drive_a(1'b0, 3, 7, -1, 0, to, ae, ab);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall_timeout done not seen"); end
    checks++; if (busy_cnt_a - busy0 !== 49) begin errors++; $display("FAIL stall_cycles got %0d want 49", busy_cnt_a - busy0); end
    checks++; if (en_cnt_a - en0 !== 36) begin errors++; $display("FAIL stall_enables got %0d want 36", en_cnt_a - en0); end
    checks++; if (viol_a - viol0 !== 0) begin errors++; $display("FAIL stall_idle_levels got %0d want 0", viol_a - viol0); end
    checks++; if (chain_a !== exp_chain_a()) begin errors++; $display("FAIL stall_chain got %h want %h", chain_a, exp_chain_a()); end
    prev_a = exp_chain_a();
  endtask

  task automatic test_start_during_shift();
    bit to; logic ae, ab;
    snap_a();
    drive_a(1'b0, -1, 0, 5, 0, to, ae, ab);
    checks++; if (en_cnt_a - en0 !== 36) begin errors++; $display("FAIL restart_enables got %0d want 36", en_cnt_a - en0); end
    checks++; if (done_cnt_a - done0 !== 1) begin errors++; $display("FAIL restart_done got %0d want 1", done_cnt_a - done0); end
    checks++; if (busy_cnt_a - busy0 !== 42) begin errors++; $display("FAIL restart_cycles got %0d want 42", busy_cnt_a - busy0); end
  endtask

  task automatic test_reset_mid();
    bit to; logic ae, ab;
    for (int i = 0; i < int'(NW_A); i++) words_a[i] = 8'($urandom);
    snap_a();
    drive_a(1'b1, -1, 0, -1, 20, to, ae, ab);
    checks++; if (ae !== 1'b0) begin errors++; $display("FAIL abort_clk_en got %b want 0", ae); end
    checks++; if (ab !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", ab); end
    checks++; if (done_cnt_a - done0 !== 0) begin errors++; $display("FAIL abort_done got %0d want 0", done_cnt_a - done0); end
    checks++; if (bus_a.err_cnt !== 16'd0) begin errors++; $display("FAIL abort_err got %0d want 0", bus_a.err_cnt); end
    for (int i = 0; i < int'(NW_A); i++) words_a[i] = 8'($urandom);
    snap_a();
    drive_a(1'b0, -1, 0, -1, 0, to, ae, ab);
    checks++; if (en_cnt_a - en0 !== 36) begin errors++; $display("FAIL reload_enables got %0d want 36", en_cnt_a - en0); end
    checks++; if (done_cnt_a - done0 !== 1) begin errors++; $display("FAIL reload_done got %0d want 1", done_cnt_a - done0); end
    checks++; if (chain_a !== exp_chain_a()) begin errors++; $display("FAIL reload_chain got %h want %h", chain_a, exp_chain_a()); end
    prev_a = exp_chain_a();
  endtask

  task automatic test_random();
    bit to; logic ae, ab; logic vm; int sw, sl, want;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < int'(NW_A); i++) words_a[i] = 8'($urandom);
      if (it % 3 == 1) words_a[$urandom_range(0, int'(NW_A) - 1)] = ~words_a[0];
      vm = 1'($urandom);
      sw = $urandom_range(0, 4);
      sl = $urandom_range(0, 5);
      want = vm ? $countones(prev_a ^ exp_chain_a()) : 0;
      snap_a();
      drive_a(vm, sw, sl, -1, 0, to, ae, ab);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rand_timeout iter %0d", it); end
      checks++;
      if (bus_a.err_cnt !== 16'(want)) begin
        errors++; $display("FAIL rand_err iter %0d got %0d want %0d", it, bus_a.err_cnt, want);
      end
      checks++;
      if (chain_a !== exp_chain_a()) begin
        errors++; $display("FAIL rand_chain iter %0d got %h want %h", it, chain_a, exp_chain_a());
      end
      checks++;
      if (busy_cnt_a - busy0 !== 42 + sl) begin
        errors++; $display("FAIL rand_cycles iter %0d got %0d want %0d", it, busy_cnt_a - busy0, 42 + sl);
      end
      prev_a = exp_chain_a();
    end
  endtask

  task automatic test_short_chain();
    bit to; int e0, b0, d0; logic [LEN_B-1:0] first;
    for (int i = 0; i < int'(NW_B); i++) words_b[i] = 8'($urandom);
    e0 = en_cnt_b; b0 = busy_cnt_b; d0 = done_cnt_b;
    drive_b(1'b0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL short_timeout done not seen"); end
    checks++; if (en_cnt_b - e0 !== 16) begin errors++; $display("FAIL short_enables got %0d want 16", en_cnt_b - e0); end
    checks++; if (busy_cnt_b - b0 !== 19) begin errors++; $display("FAIL short_cycles got %0d want 19", busy_cnt_b - b0); end
    checks++; if (done_cnt_b - d0 !== 1) begin errors++; $display("FAIL short_done got %0d want 1", done_cnt_b - d0); end
    checks++; if (chain_b !== exp_chain_b()) begin errors++; $display("FAIL short_chain got %h want %h", chain_b, exp_chain_b()); end
    first = exp_chain_b();
    drive_b(1'b1, to);
    checks++; if (bus_b.err_cnt !== 16'd0) begin errors++; $display("FAIL short_verify_same got %0d want 0", bus_b.err_cnt); end
    words_b[1][7] = ~words_b[1][7];
    drive_b(1'b1, to);
    checks++;
    if (bus_b.err_cnt !== 16'($countones(first ^ exp_chain_b()))) begin
      errors++; $display("FAIL short_verify_flip got %0d want 1", bus_b.err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_verify_same();
    test_verify_errors();
    test_stall();
    test_start_during_shift();
    test_reset_mid();
    test_random();
    test_short_chain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
